// File: rtl/knight_pkg.sv
// Shared definitions for the Knight robot link: bit timing default,
// sequencer/receiver state encodings and robot response codes.
package knight_pkg;

  localparam int BAUD_DIV_DEFAULT = 2604;  // 50 MHz / 19200 baud

  localparam logic [7:0] RESP_DONE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } seq_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA
  } rx_state_t;

  // 8N1 frame shifted out LSB first: start bit at [0], stop bit at [9].
  function automatic logic [9:0] tx_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/remote_comm_if.sv
// Host-side command/response handshake of the remote link.
interface remote_comm_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (output cmd, snd_cmd, input cmd_snt, resp_rdy, resp);
  modport slave  (input cmd, snd_cmd, output cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/remote_comm_uart.sv
// 8N1 UART: TX shifter launched by trmt, and an independent mid-bit
// sampling RX shifter with a 2-flop input synchronizer.
module remote_comm_uart
  import knight_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done,
  input  logic       rx,
  output logic       rdy,
  output logic [7:0] rx_data
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  logic [9:0]       tx_shift_reg;
  logic [CNT_W-1:0] tx_baud_reg;
  logic [3:0]       tx_bit_reg;
  logic             tx_busy_reg;

  // Pulses in the last cycle of the stop bit so a follow-on byte can be
  // loaded on the very edge the stop bit ends, leaving no idle gap.
  assign tx_done = tx_busy_reg && (tx_baud_reg == BAUD_LAST) && (tx_bit_reg == 4'd9);
  assign tx      = tx_shift_reg[0];

  always_ff @(posedge clk) begin
    if (srst) begin
      tx_shift_reg <= '1;
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_busy_reg  <= 1'b0;
    end else if (trmt) begin
      tx_shift_reg <= tx_frame(tx_data);
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_busy_reg  <= 1'b1;
    end else if (tx_busy_reg) begin
      if (tx_baud_reg == BAUD_LAST) begin
        tx_baud_reg  <= '0;
        tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
        if (tx_bit_reg == 4'd9) begin
          tx_busy_reg <= 1'b0;
        end else begin
          tx_bit_reg <= tx_bit_reg + 4'd1;
        end
      end else begin
        tx_baud_reg <= tx_baud_reg + CNT_W'(1);
      end
    end
  end

  logic [1:0]       rx_sync_reg;
  logic             rx_prev_reg;
  logic             rx_s;
  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [3:0]       rx_bit_reg, rx_bit_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic             rdy_reg, rdy_next;

  assign rx_s    = rx_sync_reg[1];
  assign rdy     = rdy_reg;
  assign rx_data = rx_data_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      rx_sync_reg  <= 2'b11;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rdy_reg      <= 1'b0;
    end else begin
      rx_sync_reg  <= {rx_sync_reg[0], rx};
      rx_prev_reg  <= rx_s;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rdy_reg      <= rdy_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rdy_next      = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_s) begin
          rx_state_next = RX_START;
          rx_cnt_next   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == BAUD_LAST) begin
          rx_cnt_next = '0;
          if (rx_bit_reg == 4'd8) begin
            // Stop sample: byte delivered regardless of its value.
            rx_data_next  = rx_shift_reg;
            rdy_next      = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            rx_shift_next = {rx_s, rx_shift_reg[7:1]};
            rx_bit_next   = rx_bit_reg + 4'd1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_W'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/remote_comm.sv
// Host-side Knight link: sends a 16-bit command as two back-to-back UART
// bytes (high first) and reports single-byte robot responses.
module remote_comm
  import knight_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,  // active-high synchronous reset despite the name
  input  logic RX,
  output logic TX,
  remote_comm_if.slave host
);

  seq_state_t state_reg, state_next;
  logic       launch_reg, launch_next;
  logic       cmd_snt_reg, cmd_snt_next;
  logic [7:0] hi_reg, lo_reg;
  logic       capture;
  logic       trmt;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       rdy;
  logic [7:0] rx_data;

  remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .srst    (rst_n),
    .trmt    (trmt),
    .tx_data (tx_byte),
    .tx      (TX),
    .tx_done (tx_done),
    .rx      (RX),
    .rdy     (rdy),
    .rx_data (rx_data)
  );

  assign host.cmd_snt  = cmd_snt_reg;
  assign host.resp_rdy = rdy;
  assign host.resp     = rx_data;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= IDLE;
      launch_reg  <= 1'b0;
      cmd_snt_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      launch_reg  <= launch_next;
      cmd_snt_reg <= cmd_snt_next;
      if (capture) begin
        hi_reg <= host.cmd[15:8];
        lo_reg <= host.cmd[7:0];
      end
    end
  end

  // The high byte is launched one cycle after acceptance (so the start bit
  // begins on the following edge); the low byte is chained on tx_done.
  always_comb begin
    state_next   = state_reg;
    launch_next  = 1'b0;
    cmd_snt_next = cmd_snt_reg;
    capture      = 1'b0;
    trmt         = 1'b0;
    tx_byte      = lo_reg;
    if (launch_reg) begin
      trmt    = 1'b1;
      tx_byte = hi_reg;
    end
    case (state_reg)
      IDLE: begin
        if (host.snd_cmd) begin
          capture      = 1'b1;
          launch_next  = 1'b1;
          cmd_snt_next = 1'b0;
          state_next   = HIGH;
        end
      end
      HIGH: begin
        if (tx_done) begin
          trmt       = 1'b1;
          tx_byte    = lo_reg;
          state_next = LOW;
        end
      end
      LOW: begin
        if (tx_done) begin
          cmd_snt_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at BAUD_DIV=16: frame timing, loopback,
// ignored requests, reset abort, RX glitch rejection and full duplex.
module tb_remote_comm;
  import knight_pkg::*;

  localparam int B = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_line;
  logic rx_line;
  logic robot_rx;
  logic loop_en;

  remote_comm_if host();

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx_line),
    .TX    (tx_line),
    .host  (host)
  );

  assign rx_line = loop_en ? tx_line : robot_rx;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_cnt  = 0;
  int multi_cnt = 0;
  logic rdy_prev = 1'b0;
  logic hist [0:511];

  always @(negedge clk) begin
    if (host.resp_rdy) begin
      rdy_cnt++;
      if (rdy_prev) multi_cnt++;
    end
    rdy_prev = host.resp_rdy;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Sends c, optionally re-pulsing snd_cmd (cmd=0) after edge N+poke_k,
  // records TX after every edge and decodes the two frames.
  task automatic send_cmd(input logic [15:0] c, input int poke_k, input logic [15:0] exp_word);
    int k;
    bit got;
    logic [7:0] byte_v;
    int base;
    @(negedge clk);
    host.cmd = c;
    host.snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    host.snd_cmd = 1'b0;
    host.cmd = 16'hDEAD;
    check_eq("accept_clears_cmd_snt", host.cmd_snt, 0);
    hist[0] = tx_line;
    k = 0;
    got = 0;
    while (k < 400 && !got) begin
      @(posedge clk);
      k++;
      #1;
      hist[k] = tx_line;
      if (host.cmd_snt) got = 1;
      host.snd_cmd = (k == poke_k);
      if (k == poke_k) host.cmd = 16'h0000;
    end
    host.snd_cmd = 1'b0;
    check_eq("cmd_snt_latency", k, 321);
    check_eq("tx_idle_at_accept", hist[0], 1);
    check_eq("tx_start_edge", hist[1], 0);
    check_eq("tx_no_gap_stop", hist[10*B], 1);
    check_eq("tx_no_gap_start", hist[1+10*B], 0);
    for (int b = 0; b < 2; b++) begin
      base = 1 + 10*b*B + B/2;
      byte_v = '0;
      check_eq("tx_start_bit", hist[base], 0);
      for (int m = 1; m <= 8; m++) byte_v[m-1] = hist[base + m*B];
      check_eq("tx_stop_bit", hist[base + 9*B], 1);
      if (b == 0) check_eq("tx_hi_byte", byte_v, exp_word[15:8]);
      else        check_eq("tx_lo_byte", byte_v, exp_word[7:0]);
    end
  endtask

  task automatic drive_rx_byte(input logic [7:0] b);
    @(negedge clk);
    robot_rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      robot_rx = b[i];
      repeat (B) @(negedge clk);
    end
    robot_rx = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  int snap;
  int tx_low_cnt;
  int snt_cnt;

  initial begin
    rst_n = 1'b1;
    loop_en = 1'b0;
    robot_rx = 1'b1;
    host.cmd = '0;
    host.snd_cmd = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("reset_tx", tx_line, 1);
    check_eq("reset_cmd_snt", host.cmd_snt, 0);
    check_eq("reset_resp_rdy", host.resp_rdy, 0);
    check_eq("reset_resp", host.resp, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Loopback: both transmitted bytes come back through the receiver.
    loop_en = 1'b1;
    send_cmd(16'h3BF2, -1, 16'h3BF2);
    repeat (40) @(negedge clk);
    check_eq("loop_rdy_count", rdy_cnt, 2);
    check_eq("loop_resp", host.resp, 8'hF2);
    loop_en = 1'b0;
    repeat (5) @(negedge clk);

    // Re-request during HIGH is ignored; then back-to-back accept, with a
    // request in the cmd_snt-rising cycle ignored.
    send_cmd(16'h3BF2, 50, 16'h3BF2);
    send_cmd(16'hC35A, 320, 16'hC35A);
    repeat (5) @(negedge clk);
    check_eq("late_req_ignored_cmd_snt", host.cmd_snt, 1);
    check_eq("late_req_ignored_tx", tx_line, 1);

    // Robot response.
    snap = rdy_cnt;
    drive_rx_byte(RESP_DONE);
    repeat (20) @(negedge clk);
    check_eq("robot_rdy_count", rdy_cnt - snap, 1);
    check_eq("robot_resp", host.resp, 8'hA5);
    repeat (30) @(negedge clk);
    check_eq("robot_resp_hold", host.resp, 8'hA5);

    // Reset in the middle of the high byte.
    @(negedge clk);
    host.cmd = 16'h3BF2;
    host.snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    host.snd_cmd = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_tx", tx_line, 1);
    check_eq("abort_cmd_snt", host.cmd_snt, 0);
    check_eq("abort_resp", host.resp, 0);
    @(negedge clk);
    rst_n = 1'b0;
    tx_low_cnt = 0;
    snt_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tx_line) tx_low_cnt++;
      if (host.cmd_snt) snt_cnt++;
    end
    check_eq("abort_tx_stays_idle", tx_low_cnt, 0);
    check_eq("abort_no_cmd_snt", snt_cnt, 0);
    send_cmd(16'h0000, -1, 16'h0000);

    // Short RX glitch must be rejected.
    snap = rdy_cnt;
    @(negedge clk);
    robot_rx = 1'b0;
    repeat (B/4) @(negedge clk);
    robot_rx = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("glitch_no_rdy", rdy_cnt - snap, 0);
    check_eq("glitch_resp_unchanged", host.resp, 0);

    // Full duplex.
    snap = rdy_cnt;
    fork
      send_cmd(16'h3BF2, -1, 16'h3BF2);
      begin
        repeat (7) @(negedge clk);
        drive_rx_byte(8'hA5);
      end
    join
    repeat (20) @(negedge clk);
    check_eq("duplex_rdy_count", rdy_cnt - snap, 1);
    check_eq("duplex_resp", host.resp, 8'hA5);
    check_eq("resp_rdy_single_cycle", multi_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
